// File: rtl/reg_file_mp.sv
// Multi-port register file with write bypass and a pending-writeback scoreboard.
// Reads are combinational; writes, issues and flushes take effect on the rising edge.
module reg_file_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reg_write_en,
  input  logic [AW-1:0]       reg_write_dest,
  input  logic [XLEN-1:0]     reg_write_data,
  input  logic [NRD*AW-1:0]   reg_read_addr,
  output logic [NRD*XLEN-1:0] reg_read_data,
  output logic [NRD-1:0]      reg_read_pend,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_dest,
  input  logic                flush,
  output logic [NREGS-1:0]    pend_vec,
  output logic [15:0]         write_count
);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [15:0]      r_wcnt;

  logic             w_wr_zero;
  logic             w_wr_commit;
  logic             w_iss_zero;
  logic             w_iss_commit;
  logic [NREGS-1:0] w_pend_set;
  logic [NREGS-1:0] w_pend_clr;
  logic [NREGS-1:0] w_pend_nxt;

  assign w_wr_zero    = (ZERO_REG != 0) && (reg_write_dest == '0);
  assign w_wr_commit  = reg_write_en && !w_wr_zero;
  assign w_iss_zero   = (ZERO_REG != 0) && (issue_dest == '0);
  assign w_iss_commit = issue_en && !w_iss_zero;

  always_comb begin
    w_pend_set = '0;
    w_pend_clr = '0;
    if (w_iss_commit)
      w_pend_set[issue_dest] = 1'b1;
    if (reg_write_en)
      w_pend_clr[reg_write_dest] = 1'b1;
  end

  // A same-cycle issue marks a new producer, so set outranks clear.
  always_comb begin
    w_pend_nxt = '0;
    if (!flush)
      w_pend_nxt = (r_pend & ~w_pend_clr) | w_pend_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_mem[i] <= '0;
    end else if (w_wr_commit) begin
      r_mem[reg_write_dest] <= reg_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pend <= '0;
    else
      r_pend <= w_pend_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wcnt <= '0;
    else if (w_wr_commit && (r_wcnt != 16'hFFFF))
      r_wcnt <= r_wcnt + 16'd1;
  end

  // Bypass is gated by rst_n so reset forces zero on every port at once.
  always_comb begin
    logic [AW-1:0] w_addr;
    logic          w_zero;
    logic          w_byp;
    reg_read_data = '0;
    reg_read_pend = '0;
    for (int k = 0; k < NRD; k++) begin
      w_addr = reg_read_addr[k*AW +: AW];
      w_zero = (ZERO_REG != 0) && (w_addr == '0);
      w_byp  = rst_n && w_wr_commit && (reg_write_dest == w_addr);
      if (w_zero)
        reg_read_data[k*XLEN +: XLEN] = '0;
      else if (w_byp)
        reg_read_data[k*XLEN +: XLEN] = reg_write_data;
      else
        reg_read_data[k*XLEN +: XLEN] = r_mem[w_addr];
      reg_read_pend[k] = rst_n && !w_zero && r_pend[w_addr] && !w_byp;
    end
  end

  assign pend_vec    = r_pend;
  assign write_count = r_wcnt;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width in bits (8..64).
REQ-002 SHALL provide parameter NREGS, default 32, number of architectural registers (power of two, 2..64); AW = log2(NREGS).
REQ-003 SHALL provide parameter NRD, default 2, number of independent read ports (1..4).
REQ-004 SHALL provide parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 reg_write_en  input  1  writeback enable.
REQ-008 reg_write_dest  input  AW  writeback register index.
REQ-009 reg_write_data  input  XLEN  writeback data.
REQ-010 reg_read_addr  input  NRD*AW  read indices, port k at bits [k*AW +: AW].
REQ-011 reg_read_data  output  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-012 reg_read_pend  output  NRD  per-port flag: the source register awaits an outstanding writeback.
REQ-013 issue_en  input  1  marks that a new producer for issue_dest has issued.
REQ-014 issue_dest  input  AW  destination register of the issued producer.
REQ-015 flush  input  1  synchronous clear of all pending bits (pipeline flush).
REQ-016 pend_vec  output  NREGS  current scoreboard state, bit i = register i pending.
REQ-017 write_count  output  16  saturating count of committed register writes.

Function
REQ-018 SHALL hold NREGS x XLEN storage and an NREGS-bit pending scoreboard.
REQ-019 SHALL write reg_write_data into reg_write_dest on a rising clk edge when reg_write_en=1, except for index 0 when ZERO_REG=1 (the write is discarded).
REQ-020 SHALL make read ports combinational: each port returns storage[addr] in the same cycle it is addressed.
REQ-021 SHALL bypass writes: if reg_write_en=1 and reg_write_dest equals a port's addr (and the addr is not 0 with ZERO_REG=1), that port SHALL return reg_write_data in the same cycle.
REQ-022 SHALL return 0 on any port addressing register 0 when ZERO_REG=1, regardless of writes or bypass.
REQ-023 SHALL set pend[issue_dest] at the clock edge when issue_en=1; with ZERO_REG=1, issue to register 0 SHALL have no effect.
REQ-024 SHALL clear pend[reg_write_dest] at the clock edge when reg_write_en=1.
REQ-025 When issue and writeback target the same register in the same cycle, set SHALL win (the new producer is outstanding).
REQ-026 When flush=1, all pend bits SHALL clear at the edge; flush SHALL override a same-cycle issue_en; storage writes SHALL proceed unaffected.
REQ-027 SHALL compute reg_read_pend[k] = pend[addr_k] AND NOT (same-cycle bypassing write to addr_k); for register 0 with ZERO_REG=1 the flag SHALL be 0.
REQ-028 SHALL increment write_count by 1 per committed write (discarded x0 writes not counted); the count SHALL saturate at 16'hFFFF.
REQ-029 Multiple read ports addressing the same register SHALL return identical data and pend flags.

Reset
REQ-030 While rst_n=0, all registers, all pend bits and write_count SHALL be 0 immediately, independent of clk.
REQ-031 During reset, reg_read_data SHALL read 0 on all ports and reg_read_pend SHALL be 0; writes and issues SHALL be ignored.
REQ-032 Reset deassertion mid-operation SHALL leave state at zero; the first edge with rst_n=1 SHALL accept write/issue normally.

Verification
REQ-033 Write 100 to r1, then 200 to r2; read ports 0/1 at r1/r2 -> 100/200, write_count=2.
REQ-034 Write 999 to r0 (ZERO_REG=1) -> port reads 0, write_count unchanged, pend[0]=0.
REQ-035 Same cycle: write 55 to r5 while port 1 reads r5 -> reg_read_data port 1 = 55 before the edge.
REQ-036 Issue r7; next cycle read r7 -> pend=1; assert write r7 = 9 -> flag 0 combinationally, pend_vec[7]=0 after the edge; issue+write r7 same cycle -> pend_vec[7]=1.
REQ-037 Issue r3, r4, then flush with issue r6 same cycle -> pend_vec all 0.
REQ-038 Load r1..r3, assert rst_n=0 between clock edges -> all reads 0, pend_vec=0, write_count=0 immediately; write after release succeeds.
